// File: rtl/systolic_matmul_if.sv
// Handshake/data bundle between the systolic matmul engine and its driver.
// Job control, streaming operand beats and the result hand-off share one interface.
interface systolic_matmul_if #(
  parameter int N    = 4,
  parameter int DW   = 10,
  parameter int KMAX = 16
);
  localparam int KW   = $clog2(KMAX + 1);
  localparam int ACCW = 2 * DW + $clog2(KMAX);

  logic                  start;
  logic [KW-1:0]         k_len;
  logic                  signed_mode;
  logic                  in_valid;
  logic                  in_ready;
  logic [N*DW-1:0]       a_col;
  logic [N*DW-1:0]       b_row;
  logic                  out_valid;
  logic                  out_ready;
  logic [N*N*ACCW-1:0]   c_flat;
  logic                  busy;

  modport master (
    output start, k_len, signed_mode, in_valid, a_col, b_row, out_ready,
    input  in_ready, out_valid, c_flat, busy
  );

  modport slave (
    input  start, k_len, signed_mode, in_valid, a_col, b_row, out_ready,
    output in_ready, out_valid, c_flat, busy
  );
endinterface

// File: rtl/systolic_matmul.sv
// N x N output-stationary systolic matrix multiplier: skewed operand injection,
// per-PE multiply-accumulate over k_len beats, results held until accepted.
module systolic_matmul #(
  parameter int N    = 4,
  parameter int DW   = 10,
  parameter int KMAX = 16
) (
  input logic               clk,
  input logic               reset,
  systolic_matmul_if.slave  bus
);
  localparam int KW   = $clog2(KMAX + 1);
  localparam int ACCW = 2 * DW + $clog2(KMAX);
  localparam int FW   = $clog2(2 * N);
  localparam int CW   = (KW > FW) ? KW : FW;
  localparam int EXTW = ACCW - 2 * DW;

  typedef enum logic [1:0] {IDLE, FEED, FLUSH, DONE} state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q;
  logic [KW-1:0]   klen_q;
  logic            sgn_q;
  logic [KW-1:0]   k_eff;
  logic            fire;
  logic            last_beat;
  logic            flush_end;
  logic            clr;

  logic [DW-1:0]   a_g    [N];
  logic [DW-1:0]   b_g    [N];
  logic [DW-1:0]   a_edge [N];
  logic [DW-1:0]   b_edge [N];
  logic [DW-1:0]   a_in   [N][N];
  logic [DW-1:0]   b_in   [N][N];
  logic [DW-1:0]   a_fwd_p1 [N][N-1];
  logic [DW-1:0]   b_fwd_p1 [N-1][N];
  logic [ACCW-1:0] acc_p1   [N][N];

  // Full-width product, sign- or zero-extended into the accumulator width.
  function automatic logic [ACCW-1:0] mul_ext(input logic [DW-1:0] a,
                                              input logic [DW-1:0] b,
                                              input logic          sgn);
    logic signed [2*DW-1:0] ps;
    logic        [2*DW-1:0] pu;
    ps = $signed(a) * $signed(b);
    pu = a * b;
    if (sgn) return {{EXTW{ps[2*DW-1]}}, ps};
    else     return {{EXTW{1'b0}}, pu};
  endfunction

  assign k_eff     = (bus.k_len > KW'(KMAX)) ? KW'(KMAX) : bus.k_len;
  assign fire      = bus.in_valid && (state_q == FEED);
  assign last_beat = fire && ((cnt_q + CW'(1)) == CW'(klen_q));
  assign flush_end = (cnt_q == CW'(2 * N - 2));
  assign clr       = (state_q == IDLE) && bus.start;

  assign bus.in_ready  = (state_q == FEED);
  assign bus.out_valid = (state_q == DONE);
  assign bus.busy      = (state_q != IDLE);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (bus.start) state_d = (k_eff == '0) ? DONE : FEED;
      FEED:    if (last_beat) state_d = FLUSH;
      FLUSH:   if (flush_end) state_d = DONE;
      DONE:    if (bus.out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // One counter serves both beat counting in FEED and the drain count in FLUSH.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q  <= '0;
      klen_q <= '0;
      sgn_q  <= 1'b0;
    end else begin
      if (state_q != state_d)                  cnt_q <= '0;
      else if (fire || (state_q == FLUSH))     cnt_q <= cnt_q + CW'(1);
      if (clr) begin
        klen_q <= k_eff;
        sgn_q  <= bus.signed_mode;
      end
    end
  end

  // Stage p0: operand gating; idle cycles inject zeros so sums are untouched.
  always_comb begin
    for (int i = 0; i < N; i++) begin
      a_g[i] = fire ? bus.a_col[i*DW +: DW] : '0;
      b_g[i] = fire ? bus.b_row[i*DW +: DW] : '0;
    end
  end

  // Row i of A and column i of B are delayed i cycles before entering the array.
  for (genvar gi = 0; gi < N; gi++) begin : g_skew
    if (gi == 0) begin : g_direct
      assign a_edge[0] = a_g[0];
      assign b_edge[0] = b_g[0];
    end else begin : g_chain
      logic [DW-1:0] a_skew_p1 [gi];
      logic [DW-1:0] b_skew_p1 [gi];
      always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
          for (int s = 0; s < gi; s++) begin
            a_skew_p1[s] <= '0;
            b_skew_p1[s] <= '0;
          end
        end else begin
          a_skew_p1[0] <= a_g[gi];
          b_skew_p1[0] <= b_g[gi];
          for (int s = 1; s < gi; s++) begin
            a_skew_p1[s] <= a_skew_p1[s-1];
            b_skew_p1[s] <= b_skew_p1[s-1];
          end
        end
      end
      assign a_edge[gi] = a_skew_p1[gi-1];
      assign b_edge[gi] = b_skew_p1[gi-1];
    end
  end

  always_comb begin
    for (int i = 0; i < N; i++) begin
      a_in[i][0] = a_edge[i];
      b_in[0][i] = b_edge[i];
    end
    for (int i = 0; i < N; i++) begin
      for (int j = 1; j < N; j++) begin
        a_in[i][j] = a_fwd_p1[i][j-1];
        b_in[j][i] = b_fwd_p1[j-1][i];
      end
    end
  end

  // Stage p1: PE registers; a moves right, b moves down, sums stay in place.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < N; i++) begin
        for (int j = 0; j < N; j++) begin
          acc_p1[i][j] <= '0;
          if (j < N - 1) a_fwd_p1[i][j] <= '0;
          if (i < N - 1) b_fwd_p1[i][j] <= '0;
        end
      end
    end else begin
      for (int i = 0; i < N; i++) begin
        for (int j = 0; j < N; j++) begin
          if (j < N - 1) a_fwd_p1[i][j] <= a_in[i][j];
          if (i < N - 1) b_fwd_p1[i][j] <= b_in[i][j];
          if (clr) acc_p1[i][j] <= '0;
          else     acc_p1[i][j] <= acc_p1[i][j] + mul_ext(a_in[i][j], b_in[i][j], sgn_q);
        end
      end
    end
  end

  for (genvar gi = 0; gi < N; gi++) begin : g_out_row
    for (genvar gj = 0; gj < N; gj++) begin : g_out_col
      assign bus.c_flat[(gi*N+gj)*ACCW +: ACCW] = acc_p1[gi][gj];
    end
  end
endmodule
